// File: rtl/intf_64bit_unpack.sv
// intf_64bit_unpack: splits 64-bit words into an LSB-first byte stream for
// one packet of pkt_len bytes. A small word buffer (1 or 2 entries) feeds a
// 64-bit shift register that emits one byte per strobe. The last word of a
// packet carries its valid bytes right-aligned; bytes above them are dropped.
// Optional feature macro INTF_UNPACK_UNDERRUN_EN adds a starvation watchdog
// with a sticky underrun output.
module intf_64bit_unpack #(
  parameter int BYTE_GAP  = 0,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [15:0] pkt_len,
  input  logic [63:0] data_in,
  input  logic        data_strobe,
  output logic        data_ready,
  output logic [7:0]  byte_out,
  output logic        byte_strobe,
  output logic [31:0] byte_index,
  output logic        busy,
  output logic        pkt_done
`ifdef INTF_UNPACK_UNDERRUN_EN
  ,
  output logic        underrun
`endif
);

  localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_WORD, SEND, GAP, DONE} state_t;

  state_t        state_q;
  logic [63:0]   buf_q [0:1];
  logic [1:0]    cnt_q;
  logic [63:0]   shift_q;
  logic [3:0]    bcnt_q;
  logic [15:0]   left_q;
  logic [15:0]   len_q;
  logic [13:0]   wacc_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    byte_out_q;
  logic          byte_strobe_q;
  logic [31:0]   byte_index_q;
  logic          busy_q;
  logic          pkt_done_q;
`ifdef INTF_UNPACK_UNDERRUN_EN
  logic [3:0]    starve_q;
  logic          underrun_q;
`endif

  logic [13:0] words_needed;
  logic        buf_empty, buf_full, push, pop;
  logic [15:0] left_dec;
  logic [1:0]  wr_idx;

  // Bytes to take from a freshly loaded word: a full word, or the remainder.
  function automatic logic [3:0] cnt_for(input logic [15:0] rem);
    return (rem > 16'd7) ? 4'd8 : {1'b0, rem[2:0]};
  endfunction

  assign words_needed = {1'b0, len_q[15:3]} + {13'd0, |len_q[2:0]};
  assign buf_empty    = (cnt_q == 2'd0);
  assign buf_full     = (cnt_q == 2'(BUF_DEPTH));
  assign data_ready   = enable & busy_q & ~buf_full & (wacc_q < words_needed);
  assign push         = data_strobe & data_ready;
  assign left_dec     = left_q - 16'd1;
  assign wr_idx       = cnt_q - {1'b0, pop};

  assign byte_out    = byte_out_q;
  assign byte_strobe = byte_strobe_q;
  assign byte_index  = byte_index_q;
  assign busy        = busy_q;
  assign pkt_done    = pkt_done_q;
`ifdef INTF_UNPACK_UNDERRUN_EN
  assign underrun    = underrun_q;
`endif

  // Buffer head is consumed whenever the shift register takes a new word.
  always_comb begin
    pop = 1'b0;
    if (enable) begin
      case (state_q)
        WAIT_WORD: pop = !buf_empty;
        SEND:      pop = (BYTE_GAP == 0) && (bcnt_q == 4'd1) &&
                         (left_dec != 16'd0) && !buf_empty;
        GAP:       pop = (gap_q == '0) && (bcnt_q == 4'd0) && !buf_empty;
        default:   pop = 1'b0;
      endcase
    end
  end

  // Word buffer, packet FSM and registered outputs; enable=0 freezes all.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      buf_q[0]      <= '0;
      buf_q[1]      <= '0;
      cnt_q         <= '0;
      shift_q       <= '0;
      bcnt_q        <= '0;
      left_q        <= '0;
      len_q         <= '0;
      wacc_q        <= '0;
      gap_q         <= '0;
      byte_out_q    <= '0;
      byte_strobe_q <= 1'b0;
      byte_index_q  <= '0;
      busy_q        <= 1'b0;
      pkt_done_q    <= 1'b0;
`ifdef INTF_UNPACK_UNDERRUN_EN
      starve_q      <= '0;
      underrun_q    <= 1'b0;
`endif
    end else begin
      byte_strobe_q <= 1'b0;
      pkt_done_q    <= 1'b0;
      if (enable) begin
        // Pop shifts entry 1 down; a same-cycle push lands behind it.
        if (pop) buf_q[0] <= buf_q[1];
        if (push) begin
          buf_q[wr_idx[0]] <= data_in;
          wacc_q           <= wacc_q + 14'd1;
        end
        cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
          IDLE: begin
            if (start) begin
              byte_index_q <= '0;
              len_q        <= pkt_len;
              left_q       <= pkt_len;
              wacc_q       <= '0;
`ifdef INTF_UNPACK_UNDERRUN_EN
              starve_q     <= '0;
              underrun_q   <= 1'b0;
`endif
              if (pkt_len == 16'd0) begin
                state_q <= DONE;
              end else begin
                busy_q  <= 1'b1;
                state_q <= WAIT_WORD;
              end
            end
          end

          WAIT_WORD: begin
            if (!buf_empty) begin
              shift_q  <= buf_q[0];
              bcnt_q   <= cnt_for(left_q);
              state_q  <= SEND;
`ifdef INTF_UNPACK_UNDERRUN_EN
              starve_q <= '0;
`endif
            end
`ifdef INTF_UNPACK_UNDERRUN_EN
            // Starvation counts only once the packet has started streaming;
            // it restarts on every successful word load.
            else if (left_q != len_q) begin
              starve_q <= starve_q + 4'd1;
              if (starve_q == 4'hE) begin
                underrun_q <= 1'b1;
                busy_q     <= 1'b0;
                cnt_q      <= '0;
                state_q    <= IDLE;
              end
            end
`endif
          end

          SEND: begin
            byte_out_q    <= shift_q[7:0];
            byte_strobe_q <= 1'b1;
            byte_index_q  <= byte_index_q + 32'd1;
            left_q        <= left_dec;
            bcnt_q        <= bcnt_q - 4'd1;
            shift_q       <= shift_q >> 8;
            if (left_dec == 16'd0) begin
              state_q <= DONE;
            end else if (BYTE_GAP != 0) begin
              gap_q   <= GW'(BYTE_GAP - 1);
              state_q <= GAP;
            end else if (bcnt_q == 4'd1) begin
              // Word exhausted: chain the next one with no bubble if present.
              if (!buf_empty) begin
                shift_q <= buf_q[0];
                bcnt_q  <= cnt_for(left_dec);
              end else begin
                state_q <= WAIT_WORD;
              end
            end
          end

          GAP: begin
            if (gap_q != '0) begin
              gap_q <= gap_q - GW'(1);
            end else if (bcnt_q != 4'd0) begin
              state_q <= SEND;
            end else if (!buf_empty) begin
              shift_q <= buf_q[0];
              bcnt_q  <= cnt_for(left_q);
              state_q <= SEND;
            end else begin
              state_q <= WAIT_WORD;
            end
          end

          DONE: begin
            pkt_done_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
